// File: rtl/reversi_pkg.sv
// rtl/reversi_pkg.sv - shared cell encodings, op/direction codes and initial-position helper
package reversi_pkg;

    localparam logic [2:0] EMPTY  = 3'b000;
    localparam logic [2:0] ENABLE = 3'b100;
    localparam logic [2:0] BLACK  = 3'b111;
    localparam logic [2:0] WHITE  = 3'b110;

    localparam logic [1:0] OP_INIT  = 2'b00;
    localparam logic [1:0] OP_MARK  = 2'b01;
    localparam logic [1:0] OP_PLACE = 2'b10;
    localparam logic [1:0] OP_FLIP  = 2'b11;

    localparam logic [2:0] DIR_N  = 3'd0;
    localparam logic [2:0] DIR_NE = 3'd1;
    localparam logic [2:0] DIR_E  = 3'd2;
    localparam logic [2:0] DIR_SE = 3'd3;
    localparam logic [2:0] DIR_S  = 3'd4;
    localparam logic [2:0] DIR_SW = 3'd5;
    localparam logic [2:0] DIR_W  = 3'd6;
    localparam logic [2:0] DIR_NW = 3'd7;

    typedef enum logic {ST_IDLE, ST_FLIP} state_e;

    // Opening position: four centre discs, same-colour diagonal pairs
    function automatic logic [2:0] init_cell(input int row, input int col, input int dim);
        int c;
        c = dim / 2;
        if ((row == c - 1 && col == c - 1) || (row == c && col == c))
            return WHITE;
        if ((row == c - 1 && col == c) || (row == c && col == c - 1))
            return BLACK;
        return EMPTY;
    endfunction

endpackage

// File: rtl/reversi_board_array_if.sv
// rtl/reversi_board_array_if.sv - command, read-port and count bundle for the board store
interface reversi_board_array_if #(
    parameter int BOARD_DIM = 8
);
    localparam int POS_W = $clog2(BOARD_DIM);
    localparam int CNT_W = $clog2(BOARD_DIM * BOARD_DIM + 1);

    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [POS_W-1:0] cmd_row;
    logic [POS_W-1:0] cmd_col;
    logic             cmd_arg;
    logic [2:0]       cmd_dir;
    logic [POS_W-1:0] cmd_len;
    logic             done;
    logic             err;
    logic [POS_W-1:0] rd_row;
    logic [POS_W-1:0] rd_col;
    logic [2:0]       rd_state;
    logic [CNT_W-1:0] black_count;
    logic [CNT_W-1:0] white_count;

    modport master (
        output cmd_valid, cmd_op, cmd_row, cmd_col, cmd_arg, cmd_dir, cmd_len, rd_row, rd_col,
        input  cmd_ready, done, err, rd_state, black_count, white_count
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_row, cmd_col, cmd_arg, cmd_dir, cmd_len, rd_row, rd_col,
        output cmd_ready, done, err, rd_state, black_count, white_count
    );

endinterface

// File: rtl/reversi_dir_step.sv
// rtl/reversi_dir_step.sv - one-cell step along a compass direction with off-board detection
module reversi_dir_step
    import reversi_pkg::*;
#(
    parameter int BOARD_DIM = 8
) (
    input  logic [$clog2(BOARD_DIM)-1:0] row,
    input  logic [$clog2(BOARD_DIM)-1:0] col,
    input  logic [2:0]                   dir,
    output logic [$clog2(BOARD_DIM)-1:0] next_row,
    output logic [$clog2(BOARD_DIM)-1:0] next_col,
    output logic                         off_board
);
    localparam int POS_W = $clog2(BOARD_DIM);

    int dr, dc, nr, nc;

    always_comb begin
        dr = 0;
        dc = 0;
        case (dir)
            DIR_N:   begin dr = -1; dc =  0; end
            DIR_NE:  begin dr = -1; dc =  1; end
            DIR_E:   begin dr =  0; dc =  1; end
            DIR_SE:  begin dr =  1; dc =  1; end
            DIR_S:   begin dr =  1; dc =  0; end
            DIR_SW:  begin dr =  1; dc = -1; end
            DIR_W:   begin dr =  0; dc = -1; end
            default: begin dr = -1; dc = -1; end
        endcase
        nr        = int'(row) + dr;
        nc        = int'(col) + dc;
        off_board = (nr < 0) || (nr >= BOARD_DIM) || (nc < 0) || (nc >= BOARD_DIM);
        next_row  = nr[POS_W-1:0];
        next_col  = nc[POS_W-1:0];
    end

endmodule

// File: rtl/reversi_board_array.sv
// rtl/reversi_board_array.sv - reversi board-state store; REVERSI_COUNT_EN builds the disc counters
module reversi_board_array
    import reversi_pkg::*;
#(
    parameter int BOARD_DIM = 8
) (
    input  logic                        clk,
    input  logic                        resetn,
    reversi_board_array_if.slave        bus
);
    localparam int POS_W = $clog2(BOARD_DIM);
    localparam int CNT_W = $clog2(BOARD_DIM * BOARD_DIM + 1);
    localparam int NCELL = BOARD_DIM * BOARD_DIM;
    localparam int IDX_W = $clog2(NCELL);

    logic [2:0]       cells_q [NCELL];
    logic [2:0]       cells_d [NCELL];
    state_e           state_q, state_d;
    logic [POS_W-1:0] cur_row_q, cur_row_d, cur_col_q, cur_col_d, rem_q, rem_d;
    logic [2:0]       dir_q, dir_d;
    logic             done_q, done_d, err_q, err_d;
    logic [2:0]       rd_state_q, rd_state_d;
`ifdef REVERSI_COUNT_EN
    logic [CNT_W-1:0] black_q, black_d, white_q, white_d;
`endif

    logic [POS_W-1:0] step_row, step_col;
    logic             step_off;
    logic [IDX_W-1:0] tgt_idx, vis_idx, rd_idx;
    logic [2:0]       vis_cell;

    reversi_dir_step #(.BOARD_DIM(BOARD_DIM)) u_dir_step (
        .row       (cur_row_q),
        .col       (cur_col_q),
        .dir       (dir_q),
        .next_row  (step_row),
        .next_col  (step_col),
        .off_board (step_off)
    );

    always_comb begin
        cells_d   = cells_q;
        state_d   = state_q;
        cur_row_d = cur_row_q;
        cur_col_d = cur_col_q;
        dir_d     = dir_q;
        rem_d     = rem_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
`ifdef REVERSI_COUNT_EN
        black_d   = black_q;
        white_d   = white_q;
`endif
        tgt_idx   = IDX_W'(int'(bus.cmd_row) * BOARD_DIM + int'(bus.cmd_col));
        vis_idx   = IDX_W'(int'(step_row) * BOARD_DIM + int'(step_col));
        vis_cell  = step_off ? EMPTY : cells_q[vis_idx];

        case (state_q)
            ST_IDLE: begin
                if (bus.cmd_valid) begin
                    done_d = 1'b1;
                    case (bus.cmd_op)
                        OP_INIT: begin
                            for (int i = 0; i < NCELL; i++)
                                cells_d[i] = init_cell(i / BOARD_DIM, i % BOARD_DIM, BOARD_DIM);
`ifdef REVERSI_COUNT_EN
                            black_d = CNT_W'(2);
                            white_d = CNT_W'(2);
`endif
                        end
                        OP_MARK: begin
                            if (!bus.cmd_arg) begin
                                for (int i = 0; i < NCELL; i++)
                                    if (cells_q[i] == ENABLE) cells_d[i] = EMPTY;
                            end else if (cells_q[tgt_idx] == EMPTY) begin
                                cells_d[tgt_idx] = ENABLE;
                            end else begin
                                err_d = 1'b1;
                            end
                        end
                        OP_PLACE: begin
                            if (cells_q[tgt_idx] == ENABLE) begin
                                for (int i = 0; i < NCELL; i++)
                                    if (cells_q[i] == ENABLE) cells_d[i] = EMPTY;
                                cells_d[tgt_idx] = bus.cmd_arg ? BLACK : WHITE;
`ifdef REVERSI_COUNT_EN
                                if (bus.cmd_arg) black_d = black_q + CNT_W'(1);
                                else             white_d = white_q + CNT_W'(1);
`endif
                            end else begin
                                err_d = 1'b1;
                            end
                        end
                        default: begin
                            // A zero-length flip completes like any single-cycle command
                            if (bus.cmd_len != '0) begin
                                done_d    = 1'b0;
                                state_d   = ST_FLIP;
                                cur_row_d = bus.cmd_row;
                                cur_col_d = bus.cmd_col;
                                dir_d     = bus.cmd_dir;
                                rem_d     = bus.cmd_len;
                            end
                        end
                    endcase
                end
            end
            default: begin
                if (vis_cell != BLACK && vis_cell != WHITE) begin
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    cells_d[vis_idx] = (vis_cell == BLACK) ? WHITE : BLACK;
`ifdef REVERSI_COUNT_EN
                    if (vis_cell == BLACK) begin
                        black_d = black_q - CNT_W'(1);
                        white_d = white_q + CNT_W'(1);
                    end else begin
                        black_d = black_q + CNT_W'(1);
                        white_d = white_q - CNT_W'(1);
                    end
`endif
                    cur_row_d = step_row;
                    cur_col_d = step_col;
                    rem_d     = rem_q - POS_W'(1);
                    if (rem_q == POS_W'(1)) begin
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
            end
        endcase

        // Read port sees this edge's writes
        rd_idx     = IDX_W'(int'(bus.rd_row) * BOARD_DIM + int'(bus.rd_col));
        rd_state_d = (int'(bus.rd_row) < BOARD_DIM && int'(bus.rd_col) < BOARD_DIM) ? cells_d[rd_idx] : EMPTY;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < NCELL; i++)
                cells_q[i] <= init_cell(i / BOARD_DIM, i % BOARD_DIM, BOARD_DIM);
            state_q    <= ST_IDLE;
            cur_row_q  <= '0;
            cur_col_q  <= '0;
            dir_q      <= '0;
            rem_q      <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            rd_state_q <= EMPTY;
`ifdef REVERSI_COUNT_EN
            black_q    <= CNT_W'(2);
            white_q    <= CNT_W'(2);
`endif
        end else begin
            cells_q    <= cells_d;
            state_q    <= state_d;
            cur_row_q  <= cur_row_d;
            cur_col_q  <= cur_col_d;
            dir_q      <= dir_d;
            rem_q      <= rem_d;
            done_q     <= done_d;
            err_q      <= err_d;
            rd_state_q <= rd_state_d;
`ifdef REVERSI_COUNT_EN
            black_q    <= black_d;
            white_q    <= white_d;
`endif
        end
    end

    assign bus.cmd_ready = (state_q == ST_IDLE);
    assign bus.done      = done_q;
    assign bus.err       = err_q;
    assign bus.rd_state  = rd_state_q;
`ifdef REVERSI_COUNT_EN
    assign bus.black_count = black_q;
    assign bus.white_count = white_q;
`else
    assign bus.black_count = '0;
    assign bus.white_count = '0;
`endif

endmodule
